// File: rtl/apb_rah_pkg.sv
// Shared definitions for the RAH packet to APB sequencer.
// Packet field positions, opcodes, response status codes and FSM states.
package apb_rah_pkg;

  localparam int PKT_W = 48;
  localparam int AW    = 12;
  localparam int DW    = 32;

  localparam int OP_HI   = 47;
  localparam int OP_LO   = 46;
  localparam int RSV_HI  = 45;
  localparam int RSV_LO  = 44;
  localparam int ADDR_HI = 43;
  localparam int ADDR_LO = 32;
  localparam int DATA_HI = 31;
  localparam int DATA_LO = 0;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam logic [1:0] ST_OKAY    = 2'b00;
  localparam logic [1:0] ST_SLVERR  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_BADCMD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } state_t;

  function automatic logic [PKT_W-1:0] make_rsp(
    input logic [1:0]    status,
    input logic [1:0]    op,
    input logic [AW-1:0] addr,
    input logic [DW-1:0] data
  );
    return {status, op, addr, data};
  endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Saturating wait-state counter for the APB ACCESS phase.
// expired is high once TIMEOUT_CYCLES-1 wait cycles have been counted.
module apb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  assign expired = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/apb_packet_sequencer.sv
// Decodes RAH command packets, runs one APB transfer each and
// returns one response packet per command, with a PREADY timeout.
module apb_packet_sequencer
  import apb_rah_pkg::*;
#(
  parameter int RAH_PACKET_WIDTH = 48,
  parameter int ADDR_WIDTH       = 12,
  parameter int DATA_WIDTH       = 32,
  parameter int TIMEOUT_CYCLES   = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [RAH_PACKET_WIDTH-1:0] cmd_data,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  output logic [RAH_PACKET_WIDTH-1:0] rsp_data,
  output logic                        rsp_wr_en,
  input  logic                        rsp_full,
  output logic                        psel,
  output logic                        penable,
  output logic                        pwrite,
  output logic [ADDR_WIDTH-1:0]       paddr,
  output logic [DATA_WIDTH-1:0]       pwdata,
  input  logic [DATA_WIDTH-1:0]       prdata,
  input  logic                        pready,
  input  logic                        pslverr
);

  state_t state;

  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  unused_rsvd;

  logic cnt_clr;
  logic cnt_en;
  logic expired;

  assign cmd_op      = cmd_data[OP_HI:OP_LO];
  assign cmd_addr    = cmd_data[ADDR_HI:ADDR_LO];
  assign cmd_wdata   = cmd_data[DATA_HI:DATA_LO];
  assign unused_rsvd = ^cmd_data[RSV_HI:RSV_LO];

  assign cnt_clr = (state == ST_SETUP);
  assign cnt_en  = (state == ST_ACCESS) && !pready;

  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_data  <= '0;
      rsp_wr_en <= 1'b0;
    end else begin
      rsp_wr_en <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            if (cmd_op[1]) begin
              rsp_data <= make_rsp(ST_BADCMD, cmd_op,
                                   cmd_addr, '0);
              state    <= ST_RESP;
            end else begin
              pwrite <= (cmd_op == OP_WRITE);
              paddr  <= cmd_addr;
              pwdata <= (cmd_op == OP_WRITE) ? cmd_wdata : '0;
              psel   <= 1'b1;
              state  <= ST_SETUP;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready has priority over an expiring counter
          if (pready) begin
            psel     <= 1'b0;
            penable  <= 1'b0;
            rsp_data <= make_rsp(
              pslverr ? ST_SLVERR : ST_OKAY,
              {1'b0, pwrite}, paddr,
              pwrite ? '0 : prdata);
            state    <= ST_RESP;
          end else if (expired) begin
            psel     <= 1'b0;
            penable  <= 1'b0;
            rsp_data <= make_rsp(ST_TIMEOUT,
                                 {1'b0, pwrite}, paddr, '0);
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!rsp_full) begin
            rsp_wr_en <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_packet_sequencer.sv
// Directed bench for apb_packet_sequencer: vector table plus
// hand sequences for backpressure and mid-transfer reset.
module tb_apb_packet_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [47:0] rsp_data;
  logic        rsp_wr_en;
  logic        rsp_full;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [47:0] cmd;
    logic [31:0] prdata;
    logic        slverr;
    int          waits;
    int          access;
    logic        bad;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [47:0] rsp;
  } vec_t;

  vec_t vecs[8];

  apb_packet_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_data (cmd_data),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .rsp_data (rsp_data),
    .rsp_wr_en(rsp_wr_en),
    .rsp_full (rsp_full),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   n;
    int   k;
    int   setups;
    int   access;
    int   lat;
    int   bad_apb;
    logic seen;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_data  = v.cmd;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = '0;
    k = 0; setups = 0; access = 0; bad_apb = 0;
    seen = 1'b0; lat = -1;
    while (k < 400 && !seen) begin
      if (rsp_wr_en) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        if (penable && !psel) bad_apb++;
        if (psel) begin
          if (paddr !== v.paddr || pwrite !== v.pwrite ||
              pwdata !== v.pwdata) bad_apb++;
          if (penable) access++;
          else setups++;
        end
        if (psel && penable) begin
          pready  = (access == v.waits + 1);
          prdata  = v.prdata;
          pslverr = v.slverr;
        end else begin
          pready  = 1'b0;
          prdata  = '0;
          pslverr = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    chk("rsp_seen", seen, 1);
    chk("setup_cycles", setups, v.bad ? 0 : 1);
    chk("access_cycles", access, v.access);
    chk("latency", lat, v.bad ? 1 : 2 + v.access);
    chk("rsp_data", rsp_data, v.rsp);
    chk("apb_stable", bad_apb, 0);
    chk("ready_low_at_wr", cmd_ready, 0);
    @(negedge clk);
    chk("single_strobe", rsp_wr_en, 0);
    chk("ready_after_wr", cmd_ready, 1);
  endtask

  initial begin
    int   strobes;
    logic [47:0] held;

    vecs[0] = '{48'h4_123_DEADBEEF, 32'h0, 1'b0, 0, 1, 1'b0,
                1'b1, 12'h123, 32'hDEADBEEF, 48'h1_123_00000000};
    vecs[1] = '{48'h0_040_00000000, 32'hCAFEF00D, 1'b0, 3, 4, 1'b0,
                1'b0, 12'h040, 32'h0, 48'h0_040_CAFEF00D};
    vecs[2] = '{48'h0_2A5_12345678, 32'h11, 1'b1, 0, 1, 1'b0,
                1'b0, 12'h2A5, 32'h0, 48'h4_2A5_00000011};
    vecs[3] = '{48'h0_0FF_00000000, 32'h55, 1'b0, 1000, 256, 1'b0,
                1'b0, 12'h0FF, 32'h0, 48'h8_0FF_00000000};
    vecs[4] = '{48'h7_3C0_A5A5A5A5, 32'hFFFFFFFF, 1'b1, 1, 2, 1'b0,
                1'b1, 12'h3C0, 32'hA5A5A5A5, 48'h5_3C0_00000000};
    vecs[5] = '{48'hC_010_00000000, 32'h0, 1'b0, 0, 0, 1'b1,
                1'b0, 12'h0, 32'h0, 48'hF_010_00000000};
    vecs[6] = '{48'h8_ABC_12345678, 32'h0, 1'b0, 0, 0, 1'b1,
                1'b0, 12'h0, 32'h0, 48'hE_ABC_00000000};
    vecs[7] = '{48'h0_7FE_00000000, 32'h0BADF00D, 1'b0, 255, 256, 1'b0,
                1'b0, 12'h7FE, 32'h0, 48'h0_7FE_0BADF00D};

    rst = 1'b1; cmd_data = '0; cmd_valid = 1'b0; rsp_full = 1'b0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {cmd_ready, psel, penable, pwrite, rsp_wr_en}, 0);
    chk("rst_paddr_pwdata", {paddr, pwdata}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // backpressure: response held for 5 cycles with rsp_full high
    rsp_full  = 1'b1;
    pready    = 1'b1;
    prdata    = 32'h12345678;
    cmd_data  = 48'h0_055_00000000;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    pready = 1'b0;
    held = rsp_data;
    chk("bp_rsp_data", held, 48'h0_055_12345678);
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_wr_en) strobes++;
      if (cmd_ready || rsp_data !== held) strobes += 100;
      @(negedge clk);
    end
    chk("bp_no_strobe_held", strobes, 0);
    rsp_full = 1'b0;
    @(negedge clk);
    chk("bp_strobe", rsp_wr_en, 1);
    chk("bp_data_at_strobe", rsp_data, 48'h0_055_12345678);
    @(negedge clk);
    chk("bp_single_strobe", {rsp_wr_en, cmd_ready}, 2'b01);

    // reset in the middle of ACCESS
    pready    = 1'b0;
    cmd_data  = 48'h4_321_0000ABCD;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_access", {psel, penable, paddr}, {2'b11, 12'h321});
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ctrl", {cmd_ready, psel, penable, pwrite, rsp_wr_en}, 0);
    chk("mid_rst_bus", {paddr, pwdata}, 0);
    rst = 1'b0;
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_wr_en || psel) strobes++;
    end
    chk("mid_rst_no_rsp", strobes, 0);

    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
